// File: rtl/io_responder_if.sv
// io_responder_if: Core-side bus into the I/O responder (address, write data/enable, read data and mux select).
interface io_responder_if #(
   parameter int AddrWidth = 9
) ();
   logic [AddrWidth-1:0] addr;
   logic [7:0]           wdata;
   logic                 we;
   logic [7:0]           rdata;
   logic                 sel;

   modport master (output addr, wdata, we, input  rdata, sel);
   modport slave  (input  addr, wdata, we, output rdata, sel);
endinterface

// File: rtl/io_responder.sv
// io_responder: LED, display, button and timer registers decoded in a 16-byte window on the Core bus.
// Define IO_IRQ_EN to add the irq output and the IRQ_MASK register at offset 0x8.
module io_responder #(
   parameter int                   AddrWidth   = 9,
   parameter logic [AddrWidth-1:0] BaseAddr    = 'h1F0,
   parameter int                   PrescaleDiv = 1000
) (
   input  logic          clk,
   input  logic          reset,
   io_responder_if.slave bus,
   input  logic [3:0]    btn_in,
   output logic [3:0]    led_out,
   output logic [15:0]   disp_out
`ifdef IO_IRQ_EN
   ,
   output logic          irq
`endif
);
   localparam int PW = (PrescaleDiv > 1) ? $clog2(PrescaleDiv) : 1;
   localparam logic [PW-1:0] PresTerm = PW'(PrescaleDiv - 1);

   logic [7:0]    rdata_q, rdata_d;
   logic          sel_q, sel_d;
   logic [3:0]    led_q, led_d;
   logic [7:0]    disp_lo_q, disp_lo_d, disp_hi_q, disp_hi_d;
   logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
   logic [3:0]    edge_q, edge_d, edge_clr;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   timer_q, timer_d;
   logic [7:0]    shadow_q, shadow_d;
   logic          ovf_q, ovf_d;
   logic          hit, rd, wr, tick, tmr_clr, wrap;
   logic [3:0]    off;
`ifdef IO_IRQ_EN
   logic [4:0]    mask_q, mask_d;
   logic          irq_q, irq_d;
`endif

   always_comb begin
      hit = bus.addr[AddrWidth-1:4] == BaseAddr[AddrWidth-1:4];
      off = bus.addr[3:0];
      rd  = hit & ~bus.we;
      wr  = hit & bus.we;

      sync1_d = btn_in;
      sync2_d = sync1_q;
      prev_d  = sync2_q;

      led_d     = (wr && off == 4'h0) ? bus.wdata[3:0] : led_q;
      disp_lo_d = (wr && off == 4'h1) ? bus.wdata      : disp_lo_q;
      disp_hi_d = (wr && off == 4'h2) ? bus.wdata      : disp_hi_q;

      // Set wins over read-clear and write-1-to-clear in the same cycle.
      edge_clr = 4'h0;
      if (rd && off == 4'h4) edge_clr = 4'hF;
      if (wr && off == 4'h4) edge_clr = bus.wdata[3:0];
      edge_d = (edge_q & ~edge_clr) | (sync2_q & ~prev_q);

      tick    = presc_q == PresTerm;
      tmr_clr = wr && off == 4'h5;
      presc_d = tick ? '0 : presc_q + PW'(1);
      timer_d = timer_q + 16'(tick);
      if (tmr_clr) begin
         presc_d = '0;
         timer_d = '0;
      end
      wrap = tick & (timer_q == 16'hFFFF) & ~tmr_clr;
      ovf_d = (ovf_q & ~(wr && off == 4'h7 && bus.wdata[0])) | wrap;

      // Reading TMR_LO freezes the high byte so a LO-then-HI read pair is coherent.
      shadow_d = (rd && off == 4'h5) ? timer_q[15:8] : shadow_q;

`ifdef IO_IRQ_EN
      mask_d = (wr && off == 4'h8) ? bus.wdata[4:0] : mask_q;
      irq_d  = |(edge_q & mask_q[3:0]) | (ovf_q & mask_q[4]);
`endif

      rdata_d = 8'h00;
      if (rd) begin
         case (off)
            4'h0:    rdata_d = {4'h0, led_q};
            4'h1:    rdata_d = disp_lo_q;
            4'h2:    rdata_d = disp_hi_q;
            4'h3:    rdata_d = {4'h0, sync2_q};
            4'h4:    rdata_d = {4'h0, edge_q};
            4'h5:    rdata_d = timer_q[7:0];
            4'h6:    rdata_d = shadow_q;
            4'h7:    rdata_d = {7'h00, ovf_q};
`ifdef IO_IRQ_EN
            4'h8:    rdata_d = {3'h0, mask_q};
`endif
            default: rdata_d = 8'h00;
         endcase
      end
      sel_d = hit;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata_q   <= '0;
         sel_q     <= 1'b0;
         led_q     <= '0;
         disp_lo_q <= '0;
         disp_hi_q <= '0;
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         edge_q    <= '0;
         presc_q   <= '0;
         timer_q   <= '0;
         shadow_q  <= '0;
         ovf_q     <= 1'b0;
`ifdef IO_IRQ_EN
         mask_q    <= '0;
         irq_q     <= 1'b0;
`endif
      end else begin
         rdata_q   <= rdata_d;
         sel_q     <= sel_d;
         led_q     <= led_d;
         disp_lo_q <= disp_lo_d;
         disp_hi_q <= disp_hi_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         edge_q    <= edge_d;
         presc_q   <= presc_d;
         timer_q   <= timer_d;
         shadow_q  <= shadow_d;
         ovf_q     <= ovf_d;
`ifdef IO_IRQ_EN
         mask_q    <= mask_d;
         irq_q     <= irq_d;
`endif
      end
   end

   assign bus.rdata = rdata_q;
   assign bus.sel   = sel_q;
   assign led_out   = led_q;
   assign disp_out  = {disp_hi_q, disp_lo_q};
`ifdef IO_IRQ_EN
   assign irq       = irq_q;
`endif
endmodule

// File: tb/tb_io_responder.sv
// tb_io_responder: scoreboard bench for io_responder; PrescaleDiv=1 so the timer ticks every clock.
module tb_io_responder;
   localparam int          AW   = 9;
   localparam logic [8:0]  BASE = 9'h1F0;

   typedef struct {
      logic [8:0] addr;
      logic [7:0] data;
      logic       sel;
   } rd_exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  btn_in = 4'h0;
   logic [3:0]  led_out;
   logic [15:0] disp_out;
`ifdef IO_IRQ_EN
   logic        irq;
`endif
   int          checks = 0;
   int          failures = 0;
   rd_exp_t     exp_q[$];
   rd_exp_t     e;
   logic [7:0]  gd;
   logic        gs;

   io_responder_if #(.AddrWidth(AW)) bus ();

   io_responder #(.AddrWidth(AW), .BaseAddr(BASE), .PrescaleDiv(1)) dut (
      .clk(clk), .reset(reset), .bus(bus), .btn_in(btn_in),
      .led_out(led_out), .disp_out(disp_out)
`ifdef IO_IRQ_EN
      , .irq(irq)
`endif
   );

   always #5 clk = ~clk;

   // All bus tasks start and end at a negedge.
   task automatic bus_write(input logic [8:0] a, input logic [7:0] d);
      bus.addr = a; bus.wdata = d; bus.we = 1'b1;
      @(negedge clk);
      bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
   endtask

   task automatic bus_read(input logic [8:0] a, output logic [7:0] d, output logic s);
      bus.addr = a; bus.we = 1'b0;
      @(negedge clk);
      d = bus.rdata; s = bus.sel;
      bus.addr = '0;
   endtask

   task automatic push_rd(input logic [8:0] a, input logic [7:0] d, input logic s);
      rd_exp_t x;
      x.addr = a; x.data = d; x.sel = s;
      exp_q.push_back(x);
   endtask

   task automatic test_reset;
      checks++;
      if (led_out !== 4'h0 || disp_out !== 16'h0 || bus.rdata !== 8'h0 || bus.sel !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: led=%h disp=%h rdata=%h sel=%b, want all 0", led_out, disp_out, bus.rdata, bus.sel);
      end
      reset = 1'b0;
      bus_write(BASE + 9'h0, 8'h0A);
      bus_write(BASE + 9'h1, 8'h55);
      checks++;
      if (led_out !== 4'hA) begin failures++; $display("FAIL led_write: led=%h want a", led_out); end
      // Reset lands in the middle of a LED read; its data must never appear.
      bus.addr = BASE; bus.we = 1'b0;
      #2 reset = 1'b1;
      @(negedge clk);
      bus.addr = '0;
      checks++;
      if (led_out !== 4'h0 || disp_out !== 16'h0 || bus.rdata !== 8'h0 || bus.sel !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid: led=%h disp=%h rdata=%h sel=%b, want all 0", led_out, disp_out, bus.rdata, bus.sel);
      end
      reset = 1'b0;
      push_rd(BASE + 9'h5, 8'h00, 1'b1);
      bus_read(BASE + 9'h5, gd, gs);
      e = exp_q.pop_front(); checks++;
      if (gd !== e.data || gs !== e.sel) begin
         failures++; $display("FAIL tmr_lo_after_reset: rdata=%h sel=%b want %h %b", gd, gs, e.data, e.sel);
      end
   endtask

   task automatic test_disp;
      bus_write(BASE + 9'h1, 8'h34);
      bus_write(BASE + 9'h2, 8'h12);
      checks++;
      if (disp_out !== 16'h1234) begin failures++; $display("FAIL disp_out: got %h want 1234", disp_out); end
      bus_write(BASE + 9'h0, 8'hFF);
      checks++;
      if (led_out !== 4'hF) begin failures++; $display("FAIL led_out: got %h want f", led_out); end
      push_rd(BASE + 9'h2, 8'h12, 1'b1);
      push_rd(BASE + 9'h1, 8'h34, 1'b1);
      push_rd(BASE + 9'h0, 8'h0F, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bus_read(exp_q[0].addr, gd, gs);
         e = exp_q.pop_front(); checks++;
         if (gd !== e.data || gs !== e.sel) begin
            failures++; $display("FAIL disp_rd @%h: rdata=%h sel=%b want %h %b", e.addr, gd, gs, e.data, e.sel);
         end
      end
   endtask

   task automatic test_btn;
      btn_in = 4'b0101;
      repeat (3) @(negedge clk);
      push_rd(BASE + 9'h3, 8'h05, 1'b1);
      push_rd(BASE + 9'h4, 8'h05, 1'b1);
      push_rd(BASE + 9'h4, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bus_read(exp_q[0].addr, gd, gs);
         e = exp_q.pop_front(); checks++;
         if (gd !== e.data || gs !== e.sel) begin
            failures++; $display("FAIL btn_rd%0d @%h: rdata=%h sel=%b want %h %b", i, e.addr, gd, gs, e.data, e.sel);
         end
      end
      btn_in = 4'b1111;
      repeat (3) @(negedge clk);
      bus_write(BASE + 9'h4, 8'h02);
      push_rd(BASE + 9'h4, 8'h08, 1'b1);
      push_rd(BASE + 9'h4, 8'h00, 1'b1);
      for (int i = 0; i < 2; i++) begin
         bus_read(exp_q[0].addr, gd, gs);
         e = exp_q.pop_front(); checks++;
         if (gd !== e.data || gs !== e.sel) begin
            failures++; $display("FAIL edge_w1c%0d: rdata=%h sel=%b want %h %b", i, gd, gs, e.data, e.sel);
         end
      end
   endtask

   task automatic test_edge_collision;
      btn_in = 4'b0000;
      repeat (4) @(negedge clk);
      btn_in = 4'b0001;
      repeat (3) @(negedge clk);
      // Bit1 rises on the very edge that samples this EDGE read.
      btn_in = 4'b0011;
      repeat (2) @(negedge clk);
      push_rd(BASE + 9'h4, 8'h01, 1'b1);
      push_rd(BASE + 9'h4, 8'h02, 1'b1);
      for (int i = 0; i < 2; i++) begin
         bus_read(exp_q[0].addr, gd, gs);
         e = exp_q.pop_front(); checks++;
         if (gd !== e.data || gs !== e.sel) begin
            failures++; $display("FAIL edge_collide%0d: rdata=%h sel=%b want %h %b", i, gd, gs, e.data, e.sel);
         end
      end
   endtask

   task automatic test_unmapped;
`ifdef IO_IRQ_EN
      bus_write(BASE + 9'h8, 8'h1F);
      push_rd(BASE + 9'h8, 8'h1F, 1'b1);
`else
      bus_write(BASE + 9'h8, 8'hFF);
      push_rd(BASE + 9'h8, 8'h00, 1'b1);
`endif
      bus_write(BASE + 9'h3, 8'hFF);
      bus_write(9'h0F0, 8'h03);
      checks++;
      if (led_out !== 4'hF) begin failures++; $display("FAIL miss_write: led=%h want f", led_out); end
      push_rd(BASE + 9'hF, 8'h00, 1'b1);
      push_rd(9'h100,      8'h00, 1'b0);
      push_rd(9'h0F0,      8'h00, 1'b0);
      push_rd(BASE + 9'h3, 8'h03, 1'b1);
      for (int i = 0; i < 5; i++) begin
         bus_read(exp_q[0].addr, gd, gs);
         e = exp_q.pop_front(); checks++;
         if (gd !== e.data || gs !== e.sel) begin
            failures++; $display("FAIL unmapped @%h: rdata=%h sel=%b want %h %b", e.addr, gd, gs, e.data, e.sel);
         end
      end
   endtask

   task automatic test_timer;
      bus_write(BASE + 9'h5, 8'h00);
      repeat (16'h02A5) @(negedge clk);
      push_rd(BASE + 9'h5, 8'hA5, 1'b1);
      push_rd(BASE + 9'h6, 8'h02, 1'b1);
      push_rd(BASE + 9'h7, 8'h00, 1'b1);
      for (int i = 0; i < 3; i++) begin
         bus_read(exp_q[0].addr, gd, gs);
         e = exp_q.pop_front(); checks++;
         if (gd !== e.data || gs !== e.sel) begin
            failures++; $display("FAIL timer_rd @%h: rdata=%h sel=%b want %h %b", e.addr, gd, gs, e.data, e.sel);
         end
      end
`ifdef IO_IRQ_EN
      bus_write(BASE + 9'h8, 8'h10);
`endif
      bus_write(BASE + 9'h5, 8'h00);
      repeat (32'hFFFF) @(negedge clk);
      // First read is sampled on the wrapping edge and still sees OVF clear.
      push_rd(BASE + 9'h7, 8'h00, 1'b1);
      push_rd(BASE + 9'h7, 8'h01, 1'b1);
      for (int i = 0; i < 2; i++) begin
         bus_read(exp_q[0].addr, gd, gs);
         e = exp_q.pop_front(); checks++;
         if (gd !== e.data || gs !== e.sel) begin
            failures++; $display("FAIL ovf_wrap%0d: rdata=%h sel=%b want %h %b", i, gd, gs, e.data, e.sel);
         end
      end
`ifdef IO_IRQ_EN
      checks++;
      if (irq !== 1'b1) begin failures++; $display("FAIL irq_set: irq=%b want 1", irq); end
`endif
      bus_write(BASE + 9'h7, 8'hFE);
      push_rd(BASE + 9'h7, 8'h01, 1'b1);
      bus_read(BASE + 9'h7, gd, gs);
      e = exp_q.pop_front(); checks++;
      if (gd !== e.data || gs !== e.sel) begin
         failures++; $display("FAIL ovf_keep: rdata=%h sel=%b want %h %b", gd, gs, e.data, e.sel);
      end
      bus_write(BASE + 9'h7, 8'h01);
`ifdef IO_IRQ_EN
      @(negedge clk);
      checks++;
      if (irq !== 1'b0) begin failures++; $display("FAIL irq_clr: irq=%b want 0", irq); end
`endif
      push_rd(BASE + 9'h7, 8'h00, 1'b1);
      bus_read(BASE + 9'h7, gd, gs);
      e = exp_q.pop_front(); checks++;
      if (gd !== e.data || gs !== e.sel) begin
         failures++; $display("FAIL ovf_clear: rdata=%h sel=%b want %h %b", gd, gs, e.data, e.sel);
      end
   endtask

   initial begin
      bus.addr = '0; bus.wdata = '0; bus.we = 1'b0;
      repeat (2) @(negedge clk);
      test_reset;
      test_disp;
      test_btn;
      test_edge_collision;
      test_unmapped;
      test_timer;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
